router_reg_parity: RTL and testbench
====================================

ROUTER_REG_PARITY -- requirements
Module: router_reg_parity

Interface
REQ-001 Parameter: DATA_W, default 8, byte width of header, payload, parity and dout.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pkt_valid  input  1  source packet byte valid; falls on the parity byte.
REQ-005 data_in  input  DATA_W  packet byte from source; [1:0] of header = destination address.
REQ-006 fifo_full  input  1  addressed FIFO full.
REQ-007 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  input  1 each  state decodes from the router FSM.
REQ-008 dout  output  DATA_W  byte to the addressed FIFO.
REQ-009 parity_done  output  1  packet parity byte received and accounted.
REQ-010 low_packet_valid  output  1  pkt_valid fell during load; FSM uses it to finish.
REQ-011 err  output  1  computed parity differs from received parity.

Function
REQ-012 Internal registers: hdr, hold, int_par, pkt_par, each DATA_W wide; all XOR arithmetic is DATA_W-bit with no carry.
REQ-013 hdr SHALL load data_in when detect_add=1, pkt_valid=1 and data_in[1:0]!=2'b11; otherwise it holds.
REQ-014 dout priority: lfd_state -> hdr; else ld_state && !fifo_full -> data_in; else laf_state -> hold; else holds.
REQ-015 hold SHALL load data_in when ld_state=1 and fifo_full=1, so no byte is lost on back-pressure.
REQ-016 int_par priority: detect_add -> 0; lfd_state -> int_par^hdr; ld_state && pkt_valid && !full_state -> int_par^data_in; else holds.
REQ-017 pkt_par: detect_add -> 0; ld_state && !pkt_valid -> data_in; else holds.
REQ-018 parity_done: detect_add -> 0; set to 1 on (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_packet_valid && !parity_done); else holds.
REQ-019 low_packet_valid: rst_int_reg -> 0; ld_state && !pkt_valid -> 1; else holds; rst_int_reg wins on conflict.
REQ-020 err: detect_add -> 0; otherwise err goes to 1 on the cycle after parity_done is 1 with int_par!=pkt_par; once set, it holds until detect_add.
REQ-021 Latency: dout is registered, one cycle after the qualifying state and data, with no combinational input-to-output path.
REQ-022 detect_add clears per-packet state (int_par, pkt_par, parity_done, err) and has priority over every other update.
REQ-023 Parity byte arriving while fifo_full=1: the byte goes to hold and pkt_par; parity_done sets via the laf_state path.
REQ-024 Address 2'b11 header: hdr unchanged, per-packet state is still cleared by detect_add.

Reset
REQ-025 While reset=1, asynchronously: dout=0, parity_done=0, low_packet_valid=0, err=0, and hdr/hold/int_par/pkt_par=0.
REQ-026 Reset mid-packet SHALL discard all packet state; normal operation resumes from detect_add after reset deasserts.
REQ-027 After reset release, no output changes until a state decode input asserts.

Verification
REQ-028 Header 8'h0D, payload 8'h11,8'h22,8'h33, parity 8'h0D, no full -> dout sequence 0D,11,22,33; parity_done=1; err=0.
REQ-029 Same packet with parity byte 8'h0E -> parity_done=1, then err=1 one cycle later; err holds until next detect_add clears it to 0.
REQ-030 fifo_full=1 during ld_state on byte 8'h22 -> hold=22, dout unchanged; then laf_state -> dout=22; int_par excludes no byte; err=0.
REQ-031 pkt_valid falls with fifo_full=1 -> low_packet_valid=1; laf_state -> parity_done=1; rst_int_reg -> low_packet_valid=0 next edge.
REQ-032 reset asserted mid-payload, asynchronous to clock -> all outputs 0 immediately; a fresh packet after release gives correct parity, err=0.
REQ-033 Header 8'h07 (address 2'b11) with detect_add -> hdr keeps its previous value; err=0, parity_done=0.

Source files
------------

// File: rtl/router_reg_parity.sv
`default_nettype none
// ============================================================================
// Module      : router_reg_parity
// Description : Router datapath register block. Captures the packet header,
//               forwards bytes to the addressed FIFO with back-pressure
//               holding, and checks the running XOR parity against the
//               received parity byte.
// Revision    : 1.0 - initial release
// ============================================================================
module router_reg_parity #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic              err
);

    logic [DATA_W-1:0] r_hdr;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_int_par;
    logic [DATA_W-1:0] r_pkt_par;

    logic w_hdr_load;
    logic w_ld_accept;
    logic w_ld_last;
    logic w_int_par_acc;
    logic w_par_done_set;
    logic w_par_mismatch;

    // Address 2'b11 is not a valid destination, so such a header is not kept.
    assign w_hdr_load     = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
    assign w_ld_accept    = ld_state && !fifo_full;
    assign w_ld_last      = ld_state && !pkt_valid;
    assign w_int_par_acc  = ld_state && pkt_valid && !full_state;
    assign w_par_done_set = (w_ld_accept && !pkt_valid) ||
                            (laf_state && low_packet_valid && !parity_done);
    assign w_par_mismatch = (r_int_par != r_pkt_par);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hdr <= '0;
        end else if (w_hdr_load) begin
            r_hdr <= data_in;
        end
    end

    // A byte presented while the FIFO is full is parked here and replayed
    // from the load-after-full state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else if (ld_state && fifo_full) begin
            r_hold <= data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (lfd_state) begin
            dout <= r_hdr;
        end else if (w_ld_accept) begin
            dout <= data_in;
        end else if (laf_state) begin
            dout <= r_hold;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_int_par <= '0;
        end else if (detect_add) begin
            r_int_par <= '0;
        end else if (lfd_state) begin
            r_int_par <= r_int_par ^ r_hdr;
        end else if (w_int_par_acc) begin
            r_int_par <= r_int_par ^ data_in;
        end
    end

    // The byte on which pkt_valid drops is the received parity byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pkt_par <= '0;
        end else if (detect_add) begin
            r_pkt_par <= '0;
        end else if (w_ld_last) begin
            r_pkt_par <= data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if (w_par_done_set) begin
            parity_done <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            low_packet_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end else if (w_ld_last) begin
            low_packet_valid <= 1'b1;
        end
    end

    // Sticky until the next header so the FSM can sample it at leisure.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (detect_add) begin
            err <= 1'b0;
        end else if (parity_done && w_par_mismatch) begin
            err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_reg_parity.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_reg_parity
// Description : Self-checking bench for router_reg_parity; packets are checked
//               against byte-order and XOR-parity expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_reg_parity;

    localparam int DATA_W = 8;

    logic              clock;
    logic              reset;
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              fifo_full;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic [DATA_W-1:0] dout;
    logic              parity_done;
    logic              low_packet_valid;
    logic              err;

    int total = 0;
    int bad   = 0;

    logic [7:0] pl_buf [16];
    logic [7:0] exp_dout;

    router_reg_parity #(.DATA_W(DATA_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        pkt_valid   = 1'b0;
        data_in     = '0;
        fifo_full   = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
    endtask

    // Drives one packet through the decode sequence an FSM would produce.
    // The expectation is packet-level: every byte (header, payload, parity)
    // reaches dout once and in order, and err reflects XOR(header,payload)
    // against the parity byte. stall_idx selects one byte (n = parity)
    // that meets a full FIFO and is replayed via load-after-full.
    task automatic run_packet(input int pid, input logic [7:0] h, input int n,
                              input logic [7:0] par, input int stall_idx);
        logic [7:0] exp_par;
        logic [7:0] b;
        logic       exp_err;
        exp_par = h;
        for (int i = 0; i < n; i++) exp_par = exp_par ^ pl_buf[i];
        exp_err = (exp_par != par);

        drive_idle();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = h;
        tick();
        total++;
        if (parity_done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL pkt%0d detect_clear: parity_done=%b err=%b, required 0 0", pid, parity_done, err);
        end

        detect_add = 1'b0; lfd_state = 1'b1; data_in = pl_buf[0];
        tick();
        exp_dout = h;
        total++;
        if (dout !== exp_dout) begin
            bad++;
            $display("FAIL pkt%0d header_out: dout=%h, required %h", pid, dout, exp_dout);
        end
        lfd_state = 1'b0;

        for (int i = 0; i <= n; i++) begin
            b = (i < n) ? pl_buf[i] : par;
            ld_state  = 1'b1;
            pkt_valid = (i < n);
            data_in   = b;
            if (i == stall_idx) begin
                fifo_full = 1'b1;
                tick();
                total++;
                if (dout !== exp_dout) begin
                    bad++;
                    $display("FAIL pkt%0d stall_hold_dout byte%0d: dout=%h, required %h", pid, i, dout, exp_dout);
                end
                fifo_full = 1'b0; ld_state = 1'b0; laf_state = 1'b1;
                tick();
                laf_state = 1'b0;
            end else begin
                fifo_full = 1'b0;
                tick();
            end
            exp_dout = b;
            total++;
            if (dout !== exp_dout) begin
                bad++;
                $display("FAIL pkt%0d byte_out byte%0d: dout=%h, required %h", pid, i, dout, exp_dout);
            end
        end

        // The parity byte has been delivered: done, still no error visible.
        total++;
        if (parity_done !== 1'b1 || low_packet_valid !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL pkt%0d parity_rx: done=%b lpv=%b err=%b, required 1 1 0",
                     pid, parity_done, low_packet_valid, err);
        end

        ld_state = 1'b0; pkt_valid = 1'b0; rst_int_reg = 1'b1;
        tick();
        total++;
        if (err !== exp_err || low_packet_valid !== 1'b0 || dout !== exp_dout) begin
            bad++;
            $display("FAIL pkt%0d err_eval: err=%b lpv=%b dout=%h, required %b 0 %h",
                     pid, err, low_packet_valid, dout, exp_err, exp_dout);
        end
        drive_idle();
        tick();
        total++;
        if (err !== exp_err || parity_done !== 1'b1) begin
            bad++;
            $display("FAIL pkt%0d err_hold: err=%b done=%b, required %b 1", pid, err, parity_done, exp_err);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        #2;
        total++;
        if (dout !== 8'h00 || parity_done !== 1'b0 || low_packet_valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: dout=%h done=%b lpv=%b err=%b, required 00 0 0 0",
                     dout, parity_done, low_packet_valid, err);
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_quiet();
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            data_in   = 8'($urandom);
            pkt_valid = 1'($urandom);
            fifo_full = 1'($urandom);
            tick();
            total++;
            if ({dout, parity_done, low_packet_valid, err} !== 11'd0) begin
                bad++;
                $display("FAIL quiet_after_reset cyc%0d: dout=%h done=%b lpv=%b err=%b, required all 0",
                         i, dout, parity_done, low_packet_valid, err);
            end
        end
        drive_idle();
    endtask

    task automatic test_known_packets();
        pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
        run_packet(1, 8'h0D, 3, 8'h0D, -1);
        run_packet(2, 8'h0D, 3, 8'h0E, -1);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (err !== 1'b1) begin
                bad++;
                $display("FAIL err_sticky cyc%0d: err=%b, required 1", i, err);
            end
        end
    endtask

    task automatic test_back_pressure();
        pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
        run_packet(3, 8'h0D, 3, 8'h0D, 1);
        run_packet(4, 8'h0D, 3, 8'h0D, 3);
        run_packet(5, 8'h0D, 3, 8'h0E, 3);
    endtask

    task automatic test_addr3();
        pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
        run_packet(6, 8'h0D, 3, 8'h0E, -1);
        drive_idle();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h07;
        tick();
        total++;
        if (err !== 1'b0 || parity_done !== 1'b0) begin
            bad++;
            $display("FAIL addr3_clear: err=%b done=%b, required 0 0", err, parity_done);
        end
        detect_add = 1'b0; lfd_state = 1'b1;
        tick();
        total++;
        if (dout !== 8'h0D) begin
            bad++;
            $display("FAIL addr3_hdr_kept: dout=%h, required 0d", dout);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_async_reset();
        drive_idle();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h45;
        tick();
        detect_add = 1'b0; lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0; ld_state = 1'b1; data_in = 8'h5A;
        tick();
        total++;
        if (dout !== 8'h5A) begin
            bad++;
            $display("FAIL pre_reset_payload: dout=%h, required 5a", dout);
        end
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({dout, parity_done, low_packet_valid, err} !== 11'd0) begin
            bad++;
            $display("FAIL async_reset: dout=%h done=%b lpv=%b err=%b, required all 0",
                     dout, parity_done, low_packet_valid, err);
        end
        drive_idle();
        tick();
        tick();
        reset = 1'b0;
        lfd_state = 1'b1;
        tick();
        total++;
        if (dout !== 8'h00) begin
            bad++;
            $display("FAIL reset_hdr_cleared: dout=%h, required 00", dout);
        end
        drive_idle();
        tick();
        pl_buf[0] = 8'hA5; pl_buf[1] = 8'h3C;
        run_packet(7, 8'h46, 2, 8'h46 ^ 8'hA5 ^ 8'h3C, -1);
    endtask

    task automatic test_random();
        logic [7:0] h;
        logic [7:0] par;
        int         n;
        int         stall;
        for (int p = 0; p < 12; p++) begin
            h = 8'($urandom);
            if (h[1:0] == 2'b11) h[1:0] = 2'($urandom_range(0, 2));
            n = int'($urandom_range(1, 8));
            par = h;
            for (int i = 0; i < n; i++) begin
                pl_buf[i] = 8'($urandom);
                par = par ^ pl_buf[i];
            end
            if ($urandom_range(0, 2) == 0) par = par ^ (8'($urandom_range(1, 255)));
            stall = int'($urandom_range(0, n + 1)) - 1;
            run_packet(100 + p, h, n, par, stall);
        end
    endtask

    initial begin
        drive_idle();
        exp_dout = '0;
        test_reset();
        test_quiet();
        test_known_packets();
        test_back_pressure();
        test_addr3();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
